// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request at a time, redirect
// squashing of stale responses, and a stallable fetch output register.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc_E,
  input  logic [63:0] PCTarget_E,
  input  logic        Stall_F,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] PC_F,
  output logic [31:0] Instr_F,
  output logic        Valid_F
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic        squash;
  logic [63:0] redirect_pc;

  assign redirect_pc = PCTarget_E & ~64'h3;
  assign imem_addr   = fetch_pc;

  // imem_req is registered: it is raised on exactly the edges that enter REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      squash   <= 1'b0;
      Valid_F  <= 1'b0;
      PC_F     <= 64'h0;
      Instr_F  <= 32'h0;
      imem_req <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          state <= WAIT;
          if (PCSrc_E) begin
            fetch_pc <= redirect_pc;
            squash   <= 1'b1;
            Valid_F  <= 1'b0;
          end
        end
        WAIT: begin
          if (PCSrc_E) begin
            fetch_pc <= redirect_pc;
            Valid_F  <= 1'b0;
            if (imem_rvalid) begin
              squash   <= 1'b0;
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              squash <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (squash) begin
              squash   <= 1'b0;
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              Instr_F  <= imem_rdata;
              PC_F     <= fetch_pc;
              Valid_F  <= 1'b1;
              fetch_pc <= fetch_pc + 64'd4;
              state    <= FULL;
            end
          end
        end
        FULL: begin
          // A redirect drops the held instruction even while Decode is stalled.
          if (PCSrc_E) begin
            fetch_pc <= redirect_pc;
            Valid_F  <= 1'b0;
            state    <= REQ;
            imem_req <= 1'b1;
          end else if (!Stall_F) begin
            Valid_F  <= 1'b0;
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
